button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 147 ++++++++++++++
 tb/tb_button_debounce.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Purpose:
//   Debounces BUTTONCOUNT independent raw push-button pins.
//   Each channel first passes through a two-flop synchronizer.
//   A new level is accepted only after it has been seen for DEBOUNCE_CYCLES
//   consecutive cycles. With the default DEBOUNCE_CYCLES of 65536, that is
//   about 1.3 ms at 50 MHz.
//   Optionally, the module also emits one-cycle press/release pulses and a
//   sticky per-channel pending flag that software can clear.
//
// Configuration macro:
//   BUTTON_EVENTS_EN
//     Defined   : press, release_o and pending are live.
//     Undefined : those outputs are tied to 0, pending_clear is ignored and
//                 no event or pending flops exist. The buttons output behaves
//                 identically in both builds.
//
// Parameters:
//   BUTTONCOUNT     number of independent channels (default 4)
//   DEBOUNCE_CYCLES stable cycles needed to accept a new level (>= 2)
//
// Ports:
//   clk            in   rising-edge clock, same as the SoC core
//   reset          in   synchronous, active-high reset
//   buttons_in     in   raw asynchronous pins, active-high
//   buttons        out  debounced level per channel
//   press          out  one-cycle pulse on each accepted 0->1 transition
//   release_o      out  one-cycle pulse on each accepted 1->0 transition
//                       ("release" is a reserved SystemVerilog keyword)
//   pending        out  sticky press flag per channel
//   pending_clear  in   per-bit clear for pending, sampled every cycle
//
// Latency:
//   A clean input change appears on buttons on rising edge
//   DEBOUNCE_CYCLES+2. Edge 1 is the edge that captures the change into the
//   first synchronizer stage.
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  output logic [BUTTONCOUNT-1:0] buttons,
  output logic [BUTTONCOUNT-1:0] press,
  output logic [BUTTONCOUNT-1:0] release_o,
  output logic [BUTTONCOUNT-1:0] pending,
  input  logic [BUTTONCOUNT-1:0] pending_clear
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("button_debounce: DEBOUNCE_CYCLES must be 2 or more");
  end

  // Synchronizer stages, per-channel counters and accepted (stable) levels.
  logic [BUTTONCOUNT-1:0] stage1_q, stage2_q;
  logic [BUTTONCOUNT-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q [BUTTONCOUNT];
  logic [CNT_W-1:0]       cnt_d [BUTTONCOUNT];
  logic [BUTTONCOUNT-1:0] accept;

  // Next-state logic for the counters and the stable level.
  // When stage2 matches the stable level, the counter is cleared. A bounce
  // back to the old level therefore discards all progress. The counter
  // stops at CNT_MAX, and the acceptance edge clears it, so it never wraps.
  always_comb begin
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned; otherwise synthesis would infer a latch.
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      accept[i]   = 1'b0;
      if (stage2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = stage2_q[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the counter array is a bank of plain flops, not a RAM.
      // Resetting it is therefore cheap, and it is needed so that reset
      // discards any debounce progress.
      stage1_q <= '0;
      stage2_q <= '0;
      stable_q <= '0;
      for (int i = 0; i < BUTTONCOUNT; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let stage2 sample the previous value
      // of stage1. With blocking assignments the synchronizer would collapse
      // into a single flop.
      stage1_q <= buttons_in;
      stage2_q <= stage1_q;
      stable_q <= stable_d;
      for (int i = 0; i < BUTTONCOUNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign buttons = stable_q;

`ifdef BUTTON_EVENTS_EN
  logic [BUTTONCOUNT-1:0] press_q, release_q, pending_q;

  // The pulses are registered on the same edge that updates stable_q.
  // Each pulse is therefore high exactly in the first cycle the new level
  // is visible on buttons.
  // In the pending update, the press term is ORed in last, so a set wins
  // over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
    end else begin
      press_q   <= accept &  stage2_q;
      release_q <= accept & ~stage2_q;
      pending_q <= (pending_q & ~pending_clear) | press_q;
    end
  end

  assign press     = press_q;
  assign release_o = release_q;
  assign pending   = pending_q;
`else
  // Event logic is compiled out. pending_clear is deliberately consumed here
  // so that it does not show up as an unused input.
  logic unused_pending_clear;
  logic [BUTTONCOUNT-1:0] unused_accept;
  assign unused_pending_clear = ^pending_clear;
  assign unused_accept        = accept;
  assign press                = '0;
  assign release_o            = '0;
  assign pending              = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed testbench for button_debounce.
//   Configuration: BUTTONCOUNT=4, DEBOUNCE_CYCLES=8.
//   Acceptance:    on edge 10 after a clean change.
// Event expectations follow BUTTON_EVENTS_EN:
//   Defined   : press, release_o and pending are expected to be live.
//   Undefined : press, release_o and pending are expected to stay at zero.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int N   = 4;
  localparam int DC  = 8;
  localparam int ACC = DC + 2;  // edge on which a clean change is accepted
`ifdef BUTTON_EVENTS_EN
  localparam bit EV = 1'b1;
`else
  localparam bit EV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] buttons_in, pending_clear;
  logic [N-1:0] buttons, press, release_o, pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  button_debounce #(.BUTTONCOUNT(N), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .buttons_in   (buttons_in),
    .buttons      (buttons),
    .press        (press),
    .release_o    (release_o),
    .pending      (pending),
    .pending_clear(pending_clear)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    buttons_in    = '1;
    pending_clear = '0;
    tick();
    tick();
    total_cnt++;
    if ({buttons, press, release_o, pending} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {buttons, press, release_o, pending});
    else
      pass_cnt++;
    buttons_in = '0;
    tick();
    reset = 1'b0;
    // Flush the synchronizers with the pins at 0.
    for (int k = 0; k < 4; k++) tick();
    total_cnt++;
    if ({buttons, press, release_o, pending} !== '0)
      $display("FAIL reset_idle: got %h required 0",
               {buttons, press, release_o, pending});
    else
      pass_cnt++;
  endtask

  // Channel 0 steps 0->1. Expect:
  //   buttons[0] rises on edge 10, press[0] is high on edge 10 only,
  //   pending[0] is set on edge 11.
  task automatic test_press();
    buttons_in[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++;
      if (buttons !== ((k >= ACC) ? 4'b0001 : 4'b0000))
        $display("FAIL press_buttons k=%0d: got %b required %b", k, buttons,
                 (k >= ACC) ? 4'b0001 : 4'b0000);
      else
        pass_cnt++;
      total_cnt++;
      if (press !== ((EV && k == ACC) ? 4'b0001 : 4'b0000))
        $display("FAIL press_pulse k=%0d: got %b", k, press);
      else
        pass_cnt++;
      total_cnt++;
      if (pending !== ((EV && k >= ACC + 1) ? 4'b0001 : 4'b0000))
        $display("FAIL press_pending k=%0d: got %b", k, pending);
      else
        pass_cnt++;
      total_cnt++;
      if (release_o !== 4'b0000)
        $display("FAIL press_no_release k=%0d: got %b required 0000", k,
                 release_o);
      else
        pass_cnt++;
    end
  endtask

  // Channel 1 is high for 5 cycles and low for 1, then stays high. Expect
  // no acceptance during the glitch, and acceptance 10 edges after the
  // final rise.
  task automatic test_glitch();
    buttons_in[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) buttons_in[1] = 1'b0;
      tick();
      total_cnt++;
      if (buttons[1] !== 1'b0 || press[1] !== 1'b0)
        $display("FAIL glitch_hold k=%0d: got buttons=%b press=%b required 0",
                 k, buttons[1], press[1]);
      else
        pass_cnt++;
    end
    buttons_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++;
      if (buttons[1] !== (k >= ACC))
        $display("FAIL glitch_buttons k=%0d: got %b required %b", k,
                 buttons[1], k >= ACC);
      else
        pass_cnt++;
      total_cnt++;
      if (press[1] !== (EV && k == ACC))
        $display("FAIL glitch_press k=%0d: got %b", k, press[1]);
      else
        pass_cnt++;
    end
  endtask

  // Channel 2 goes high and is accepted, then goes low. Expect a
  // single-cycle release[2] pulse 10 edges after the fall, with pending[2]
  // staying set.
  task automatic test_release();
    buttons_in[2] = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    total_cnt++;
    if (buttons[2] !== 1'b1)
      $display("FAIL release_setup: got %b required 1", buttons[2]);
    else
      pass_cnt++;
    buttons_in[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++;
      if (buttons[2] !== (k < ACC))
        $display("FAIL release_buttons k=%0d: got %b required %b", k,
                 buttons[2], k < ACC);
      else
        pass_cnt++;
      total_cnt++;
      if (release_o[2] !== (EV && k == ACC) || press[2] !== 1'b0)
        $display("FAIL release_pulse k=%0d: got release=%b press=%b", k,
                 release_o[2], press[2]);
      else
        pass_cnt++;
      total_cnt++;
      if (pending[2] !== EV)
        $display("FAIL release_pending k=%0d: got %b required %b", k,
                 pending[2], EV);
      else
        pass_cnt++;
    end
  endtask

  // pending_clear alone clears the flag. A clear coincident with a new
  // press leaves the flag set.
  task automatic test_pending_clear();
    pending_clear[0] = 1'b1;
    tick();
    pending_clear[0] = 1'b0;
    total_cnt++;
    if (pending !== {1'b0, EV, EV, 1'b0})
      $display("FAIL clear_alone: got %b required %b", pending,
               {1'b0, EV, EV, 1'b0});
    else
      pass_cnt++;
    // Release channel 0. A release must not set pending.
    buttons_in[0] = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    total_cnt++;
    if (buttons[0] !== 1'b0 || pending[0] !== 1'b0)
      $display("FAIL clear_after_release: got buttons=%b pending=%b",
               buttons[0], pending[0]);
    else
      pass_cnt++;
    buttons_in[0] = 1'b1;
    for (int k = 1; k <= ACC; k++) tick();
    total_cnt++;
    if (press[0] !== EV)
      $display("FAIL clear_new_press: got %b required %b", press[0], EV);
    else
      pass_cnt++;
    // The clear is sampled together with the press; the set must win.
    pending_clear[0] = 1'b1;
    tick();
    total_cnt++;
    if (pending[0] !== EV)
      $display("FAIL clear_set_wins: got %b required %b", pending[0], EV);
    else
      pass_cnt++;
    tick();
    pending_clear[0] = 1'b0;
    total_cnt++;
    if (pending[0] !== 1'b0 || pending[1] !== EV)
      $display("FAIL clear_second: got %b required %b", pending[1:0],
               {EV, 1'b0});
    else
      pass_cnt++;
  endtask

  // Reset is pulsed on cycle 6 of a debounce on channel 3. Channels 0, 1
  // and 3 stay high, so all three re-accept together after reset.
  task automatic test_reset_mid();
    buttons_in[3] = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    reset = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total_cnt++;
      if ({buttons, press, release_o, pending} !== '0)
        $display("FAIL reset_mid_zero k=%0d: got %h required 0", k,
                 {buttons, press, release_o, pending});
      else
        pass_cnt++;
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      total_cnt++;
      if (buttons !== ((k >= ACC) ? 4'b1011 : 4'b0000))
        $display("FAIL reset_mid_buttons k=%0d: got %b", k, buttons);
      else
        pass_cnt++;
      total_cnt++;
      if (press !== ((EV && k == ACC) ? 4'b1011 : 4'b0000))
        $display("FAIL reset_mid_press k=%0d: got %b", k, press);
      else
        pass_cnt++;
      total_cnt++;
      if (pending !== ((EV && k > ACC) ? 4'b1011 : 4'b0000))
        $display("FAIL reset_mid_pending k=%0d: got %b", k, pending);
      else
        pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_pending_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
